// File: rtl/key_expansion_seq_if.sv
// rtl/key_expansion_seq_if.sv - control and round-key stream bundle for the AES-128 key schedule
interface key_expansion_seq_if;
  logic              start;
  logic [127:0]      key;
  logic              rk_ready;
  logic              rk_valid;
  logic [3:0]        rk_round;
  logic [3:0][31:0]  rk;
  logic              busy;
  logic              done;

  // master: the key schedule producing round keys; slave: the round controller
  modport master (
    input  start, key, rk_ready,
    output rk_valid, rk_round, rk, busy, done
  );

  modport slave (
    output start, key, rk_ready,
    input  rk_valid, rk_round, rk, busy, done
  );
endinterface

// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - word-serial AES-128 key schedule presenting round keys 0..10
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0)
  always_comb begin
    sq  = in_i;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_expansion_seq #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  key_expansion_seq_if.master  bus
);
  typedef enum logic [1:0] {IDLE, PRESENT, EXPAND} state_t;

  state_t           state_q, state_d;
  logic [3:0][31:0] w_q, w_d;
  logic [3:0]       round_q, round_d;
  logic [1:0]       j_q, j_d;
  logic             done_q, done_d;
  logic [31:0]      rot_w3;
  logic [31:0]      sub_w3;
  logic [7:0]       rcon;

  assign rot_w3 = {w_q[3][23:0], w_q[3][31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.in_i(rot_w3[8*b +: 8]), .out_o(sub_w3[8*b +: 8]));
  end

  // Rcon for the round being built, i.e. Rcon[round_q + 1]
  always_comb begin
    case (round_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    j_d     = j_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          w_d[0]  = bus.key[127:96];
          w_d[1]  = bus.key[95:64];
          w_d[2]  = bus.key[63:32];
          w_d[3]  = bus.key[31:0];
          round_d = 4'd0;
          j_d     = 2'd0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.rk_ready) begin
          if (round_q == 4'(NR)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = EXPAND;
            j_d     = 2'd0;
          end
        end
      end
      EXPAND: begin
        // Words update in place; j=0 still sees the previous round's w[3]
        if (j_q == 2'd0) w_d[0] = w_q[0] ^ sub_w3 ^ {rcon, 24'h000000};
        else             w_d[j_q] = w_q[j_q] ^ w_q[j_q - 2'd1];
        j_d = j_q + 2'd1;
        if (j_q == 2'd3) begin
          round_d = round_q + 4'd1;
          state_d = PRESENT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      round_q <= 4'd0;
      j_q     <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk_valid = (state_q == PRESENT);
  assign bus.rk_round = round_q;
  assign bus.rk       = w_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - directed bench for the AES-128 word-serial key schedule
module tb_key_expansion_seq;
  typedef logic [3:0][31:0] rk_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam rk_t FIPS_R0  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam rk_t FIPS_R1  = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam rk_t FIPS_R2  = {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2};
  localparam rk_t FIPS_R10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam rk_t ZERO_R1  = {32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363};
  localparam rk_t ZERO_R10 = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  key_expansion_seq_if bus ();

  key_expansion_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_start(input logic [127:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rk_valid) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
  endtask

  task automatic drain(output int done_cnt, output bit ok);
    done_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (!bus.busy && !bus.done && done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.key      = '0;
    bus.rk_ready = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.rk_valid !== 1'b0) $display("FAIL reset_rk_valid: got %b want 0", bus.rk_valid); else passed++;
    checks++; if (bus.rk_round !== 4'd0) $display("FAIL reset_rk_round: got %0d want 0", bus.rk_round); else passed++;
    checks++; if (bus.rk !== '0) $display("FAIL reset_rk: got %h want 0", bus.rk); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_fips_schedule();
    int gap;
    bit ok;
    int cycles;
    bit gaps_ok;
    bus.rk_ready = 1'b1;
    do_start(FIPS_KEY);
    checks++; if (bus.rk_valid !== 1'b1) $display("FAIL start_latency: rk_valid got %b want 1", bus.rk_valid); else passed++;
    checks++; if (bus.rk_round !== 4'd0) $display("FAIL fips_r0_round: got %0d want 0", bus.rk_round); else passed++;
    checks++; if (bus.rk !== FIPS_R0) $display("FAIL fips_r0_rk: got %h want %h", bus.rk, FIPS_R0); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL fips_busy: got %b want 1", bus.busy); else passed++;
    cycles  = 0;
    gaps_ok = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      wait_valid(gap, ok);
      if (!ok) begin
        checks++;
        $display("FAIL fips_timeout: round %0d never presented", r);
        return;
      end
      cycles += gap + 1;
      if (gap != 4) gaps_ok = 1'b0;
      checks++; if (bus.rk_round !== 4'(r)) $display("FAIL fips_round_idx: got %0d want %0d", bus.rk_round, r); else passed++;
      if (r == 1) begin
        checks++; if (bus.rk !== FIPS_R1) $display("FAIL fips_r1_rk: got %h want %h", bus.rk, FIPS_R1); else passed++;
      end
      if (r == 2) begin
        checks++; if (bus.rk !== FIPS_R2) $display("FAIL fips_r2_rk: got %h want %h", bus.rk, FIPS_R2); else passed++;
      end
      if (r == 10) begin
        checks++; if (bus.rk !== FIPS_R10) $display("FAIL fips_r10_rk: got %h want %h", bus.rk, FIPS_R10); else passed++;
      end
    end
    checks++; if (gaps_ok !== 1'b1) $display("FAIL fips_gaps: some invalid gap was not 4 cycles"); else passed++;
    @(negedge clk);
    cycles++;
    checks++; if (bus.done !== 1'b1) $display("FAIL fips_done: got %b want 1", bus.done); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL fips_done_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.rk_valid !== 1'b0) $display("FAIL fips_done_valid: got %b want 0", bus.rk_valid); else passed++;
    checks++; if (cycles !== 51) $display("FAIL fips_cycles: got %0d want 51", cycles); else passed++;
  endtask

  task automatic test_back_to_back_zero_key();
    int gap;
    bit ok;
    int done_cnt;
    do_start('0);
    checks++; if (bus.done !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", bus.done); else passed++;
    checks++; if (bus.rk_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", bus.rk_valid); else passed++;
    checks++; if (bus.rk !== '0) $display("FAIL zero_r0_rk: got %h want 0", bus.rk); else passed++;
    for (int r = 1; r <= 10; r++) begin
      wait_valid(gap, ok);
      if (!ok) begin
        checks++;
        $display("FAIL zero_timeout: round %0d never presented", r);
        return;
      end
      if (r == 1) begin
        checks++; if (bus.rk !== ZERO_R1) $display("FAIL zero_r1_rk: got %h want %h", bus.rk, ZERO_R1); else passed++;
      end
      if (r == 10) begin
        checks++; if (bus.rk !== ZERO_R10) $display("FAIL zero_r10_rk: got %h want %h", bus.rk, ZERO_R10); else passed++;
      end
    end
    drain(done_cnt, ok);
    checks++; if (!ok || done_cnt != 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    int  gap;
    bit  ok;
    int  done_cnt;
    rk_t held;
    bit  stable;
    bus.rk_ready = 1'b1;
    do_start(FIPS_KEY);
    for (int r = 1; r <= 3; r++) wait_valid(gap, ok);
    checks++; if (!ok || bus.rk_round !== 4'd3) $display("FAIL bp_reach_r3: got %0d want 3", bus.rk_round); else passed++;
    bus.rk_ready = 1'b0;
    held   = bus.rk;
    stable = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd3 || bus.rk !== held) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) $display("FAIL bp_stable: outputs changed while stalled, rk=%h round=%0d", bus.rk, bus.rk_round); else passed++;
    bus.rk_ready = 1'b1;
    wait_valid(gap, ok);
    checks++; if (!ok || gap != 4) $display("FAIL bp_gap: got %0d want 4", gap); else passed++;
    checks++; if (bus.rk_round !== 4'd4) $display("FAIL bp_r4_round: got %0d want 4", bus.rk_round); else passed++;
    drain(done_cnt, ok);
    checks++; if (!ok || done_cnt != 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_start_ignored();
    int gap;
    bit ok;
    bus.rk_ready = 1'b1;
    do_start(FIPS_KEY);
    wait_valid(gap, ok);
    @(negedge clk);
    bus.key   = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", bus.busy); else passed++;
    for (int r = 2; r <= 10; r++) begin
      wait_valid(gap, ok);
      if (!ok) begin
        checks++;
        $display("FAIL ign_timeout: round %0d never presented", r);
        return;
      end
      if (r == 2) begin
        checks++; if (bus.rk !== FIPS_R2) $display("FAIL ign_r2_rk: got %h want %h", bus.rk, FIPS_R2); else passed++;
      end
      if (r == 10) begin
        checks++; if (bus.rk !== FIPS_R10) $display("FAIL ign_r10_rk: got %h want %h", bus.rk, FIPS_R10); else passed++;
      end
    end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) $display("FAIL ign_done: got %b want 1", bus.done); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL ign_done_width: got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_reset_mid();
    int gap;
    bit ok;
    int done_cnt;
    bit saw_done;
    bus.rk_ready = 1'b1;
    do_start(FIPS_KEY);
    for (int r = 1; r <= 5; r++) wait_valid(gap, ok);
    checks++; if (!ok || bus.rk_round !== 4'd5) $display("FAIL rst_reach_r5: got %0d want 5", bus.rk_round); else passed++;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL rst_ctrl: valid=%b busy=%b done=%b want 0", bus.rk_valid, bus.busy, bus.done); else passed++;
    checks++; if (bus.rk_round !== 4'd0) $display("FAIL rst_round: got %0d want 0", bus.rk_round); else passed++;
    checks++; if (bus.rk !== '0) $display("FAIL rst_rk: got %h want 0", bus.rk); else passed++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL rst_no_done: got done pulse want none"); else passed++;
    do_start(FIPS_KEY);
    checks++; if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd0) $display("FAIL rst_restart: valid=%b round=%0d want 1/0", bus.rk_valid, bus.rk_round); else passed++;
    checks++; if (bus.rk !== FIPS_R0) $display("FAIL rst_restart_rk: got %h want %h", bus.rk, FIPS_R0); else passed++;
    drain(done_cnt, ok);
    checks++; if (!ok || done_cnt != 1) $display("FAIL rst_done_count: got %0d want 1", done_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_fips_schedule();
    test_back_to_back_zero_key();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
- Word-serial AES-128 key schedule. Directly upstream of the add-round-key stage.
- Captures a 128-bit cipher key, then presents round keys 0..10 one at a time.
- Each round key is presented in the same packed word order the add-round-key stage consumes: word 0 maps to state bits [127:96].
- Each new round key is computed one 32-bit word per cycle, in place, under a valid/ready handshake with the round controller.

Parameters:
- NR, 10, number of rounds after round 0 (AES-128). Fixed; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a schedule with key; sampled only in IDLE
- key  input  128  cipher key; key[127:96] is word 0
- rk_ready  input  1  consumer accepts the presented round key
- rk_valid  output  1  rk and rk_round are valid
- rk_round  output  4  index of the presented round key, 0..10
- rk  output  [3:0][31:0]  round key; rk[0] = first word (pairs with state[127:96])
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; w registers=0; round=0; word counter j=0.
  - rk_valid=0, rk_round=0, rk=0, busy=0, done=0.
  - Reset mid-schedule aborts immediately; no done pulse is produced.
- States: IDLE, PRESENT, EXPAND. All outputs are registered or decoded from registers only.
- IDLE:
  - On start=1: w[0..3] <= key words, round <= 0; go to PRESENT.
  - rk_valid is high the cycle after start is sampled (1-cycle latency).
- PRESENT:
  - rk_valid=1. rk, rk_round and w hold stable until the handshake.
  - Handshake = rk_valid & rk_ready at a rising edge.
    - If round==10: go to IDLE; done=1 for exactly the next cycle.
    - Otherwise: go to EXPAND with j=0.
  - rk_ready while rk_valid=0 is ignored.
- EXPAND (4 cycles, j=0..3, rk_valid=0):
  - j=0: w[0] <= w[0] ^ SubWord(RotWord(w[3])) ^ {Rcon[round+1], 24'h0}. w[3] is still the old value.
  - j=1..3: w[j] <= w[j] ^ w[j-1], using the already-updated w[j-1].
  - After j=3: round <= round+1; go to PRESENT.
  - Handshake-to-next-valid gap: rk_valid is low for exactly 4 cycles.
- RotWord: {b1,b2,b3,b0} of {b0,b1,b2,b3}, where b0 = bits [31:24].
- SubWord: four instances of the team's combinational 8-bit S-box, one per byte.
- Rcon[1..10]: 01,02,04,08,10,20,40,80,1B,36. Implemented as a case on round; no multiply logic.
- start is ignored outside IDLE; key changes after capture have no effect.
- start asserted in the same cycle done is high: accepted, because the FSM is already in IDLE.
- busy is high from the cycle after start through the final handshake cycle.
- Full schedule with rk_ready tied high: 11 presents + 40 expand cycles = 51 cycles from first rk_valid to done.
- The round counter never exceeds 10; wrap-around is impossible by construction.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0: rk = key, rk_round=0.
  - round 1: rk = a0fafe17 88542cb1 23a33939 2a6c7605.
  - round 2: rk = f2c295f2 7a96b943 5935807a 7359f67f.
- Same key, full run:
  - round 10: rk = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - done pulses once, one cycle after that handshake; then busy=0 and rk_valid=0.
- Backpressure: hold rk_ready=0 for 7 cycles at round 3.
  - rk, rk_round and rk_valid stay stable.
  - After the handshake, rk_valid is low exactly 4 cycles, then round 4 is presented.
- start pulsed during EXPAND with a different key: ignored; the schedule completes with the original key's values.
- Assert reset_n=0 asynchronously mid-EXPAND at round 5:
  - All outputs go to 0 immediately; no done pulse.
  - A new start afterwards yields a correct round 0.
- Key of all zeros: round 1 = 62636363 62636363 62636363 62636363; round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
